mdu_arbiter: RTL and testbench
==============================

# mdu_arbiter

Sequencer and arbiter for the shared multiply/divide unit in the dual-issue execute stage. It accepts MULT/MULTU/DIV/DIVU requests from pipe 0 and pipe 1, grants one at a time, and issues a one-cycle op pulse to the unit. It waits for the unit's `done` rising edge, then writes the 64-bit {HI,LO} result through a single registered write port. It also generates stalls for losing requesters and for HI/LO reads while an operation is in flight.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles before the watchdog aborts the operation.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  kills any un-committed operation.
- `req0` / `req1`  in  1  pipe 0/1 requests a mult/div.
- `op0` / `op1`  in  2  10 = signed, 01 = unsigned.
- `is_div0` / `is_div1`  in  1  1 = divide, 0 = multiply.
- `a0`, `b0`, `a1`, `b1`  in  32  operands (a = dividend/multiplicand).
- `hilo_rd0` / `hilo_rd1`  in  1  pipe reads HI/LO this cycle (MFHI/MFLO).
- `grant0` / `grant1`  out  1  combinational; request accepted this cycle.
- `stall0` / `stall1`  out  1  combinational pipe stall.
- `mult_op`, `div_op`  out  2  registered op pulse to the unit.
- `unit_a`, `unit_b`  out  32  latched operands, held stable until IDLE.
- `mult_done`, `div_done`  in  1  unit done levels.
- `mult_res`, `div_res`  in  64  unit results.
- `hilo_we`  out  1  one-cycle write strobe.
- `hilo_wdata`  out  64  {HI,LO} write data.
- `busy`  out  1  state ≠ IDLE.
- `timeout_err`  out  1  sticky watchdog flag; cleared only by `rst`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, COMMIT.
- IDLE: a grant is possible only if `!flush`.
  - One request: that requester is granted.
  - Both requesting: pipe 0 wins (see Configuration).
  - On grant: latch operands, op, is_div and owner; go to ISSUE.
- ISSUE: drive `mult_op` or `div_op` = latched op for exactly one cycle; go to WAIT.
- WAIT: edge-detect the selected done (`done & ~done_prev`; `done_prev` is reset to 1).
  - On rise: latch the selected result; go to COMMIT.
  - `flush` in ISSUE/WAIT sets a kill flag. The op still runs to its done rise, but COMMIT is suppressed.
- COMMIT: `hilo_we` = !kill, `hilo_wdata` = latched result; clear kill; go to IDLE.
- Watchdog: counter cleared on entering WAIT, incremented each WAIT cycle. Reaching `TIMEOUT` sets `timeout_err` and returns to IDLE with no write.
- Stalls:
  - `stallN` = (`reqN` & !`grantN`) | (`hilo_rdN` & `busy`).
  - A granted requester is not stalled.
- Reset values: state IDLE; all outputs 0 except `unit_a`/`unit_b` = 0; kill = 0; counter = 0.
- Reset mid-operation abandons the operation with no HI/LO write.

## Timing
- Request at cycle T in IDLE: grant at T; op pulse at T+1; WAIT from T+2.
- Done rise sampled at cycle C: `hilo_we` at C+1, IDLE at C+2.
- Earliest next grant is C+2.
- Minimum occupancy is 4 cycles (done rising at T+2).
- `flush` and a request in the same IDLE cycle: no grant.
- `flush` in the COMMIT cycle does not suppress the write; the result is already architecturally committed.
- Done already high with no rise: the unit keeps waiting; only a 0→1 edge commits.

## Configuration
- `MDU_RR_ARB_EN` defined: round-robin arbitration.
  - A priority pointer flips to the other pipe after every grant.
  - The pointer resets to pipe 0.
- `MDU_RR_ARB_EN` undefined: fixed priority, pipe 0 always wins.

## Test plan
- MULT: `req0`, op=10, a=0xFFFFFFFE, b=3; unit done rises 5 cycles after the pulse -> `mult_op`=10 for one cycle, then `hilo_we` with 0xFFFFFFFF_FFFFFFFA; `busy` low two cycles after the done rise.
- Simultaneous `req0`/`req1` (DIVU 7/2 and MULTU 3/4):
  - Fixed priority -> pipe 0 granted first; `stall1` high until the next IDLE; hilo writes 0x00000001_00000003 then 0x00000000_0000000C.
  - With `MDU_RR_ARB_EN` -> after a prior pipe 0 grant, pipe 1 is granted first.
- Flush during WAIT of a MULT 2×2 -> FSM still waits for the done rise; no `hilo_we`; next request granted normally.
- `hilo_rd1` while `busy` -> `stall1`=1 every busy cycle; drops in the cycle `busy` falls.
- Done never rises, `TIMEOUT`=8 -> `timeout_err`=1 after 8 WAIT cycles; return to IDLE; no write; flag stays set until `rst`.
- `rst` asserted in WAIT -> next cycle IDLE, all outputs 0, no write on a later done rise.

Source files
------------

// File: rtl/mdu_arbiter_if.sv
// Pipe-side request/stall and unit-side op/done/result signals of the shared mult/div sequencer.
interface mdu_arbiter_if;
   logic        flush;
   logic        req0;
   logic        req1;
   logic [1:0]  op0;
   logic [1:0]  op1;
   logic        is_div0;
   logic        is_div1;
   logic [31:0] a0;
   logic [31:0] b0;
   logic [31:0] a1;
   logic [31:0] b1;
   logic        hilo_rd0;
   logic        hilo_rd1;
   logic        grant0;
   logic        grant1;
   logic        stall0;
   logic        stall1;
   logic [1:0]  mult_op;
   logic [1:0]  div_op;
   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic        mult_done;
   logic        div_done;
   logic [63:0] mult_res;
   logic [63:0] div_res;
   logic        hilo_we;
   logic [63:0] hilo_wdata;
   logic        busy;
   logic        timeout_err;

   modport master (
      output flush, req0, req1, op0, op1, is_div0, is_div1, a0, b0, a1, b1,
             hilo_rd0, hilo_rd1, mult_done, div_done, mult_res, div_res,
      input  grant0, grant1, stall0, stall1, mult_op, div_op, unit_a, unit_b,
             hilo_we, hilo_wdata, busy, timeout_err
   );

   modport slave (
      input  flush, req0, req1, op0, op1, is_div0, is_div1, a0, b0, a1, b1,
             hilo_rd0, hilo_rd1, mult_done, div_done, mult_res, div_res,
      output grant0, grant1, stall0, stall1, mult_op, div_op, unit_a, unit_b,
             hilo_we, hilo_wdata, busy, timeout_err
   );
endinterface

// File: rtl/mdu_arbiter.sv
// Two-pipe sequencer for the shared mult/div unit: grant, issue pulse, wait for done edge, commit HI/LO.
// MDU_RR_ARB_EN selects round-robin arbitration; otherwise pipe 0 has fixed priority.
module mdu_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   mdu_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic          is_div_q, is_div_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic          kill_q, kill_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    mult_op_q, mult_op_d;
   logic [1:0]    div_op_q, div_op_d;
   logic          hilo_we_q, hilo_we_d;
   logic [63:0]   hilo_wdata_q, hilo_wdata_d;
   logic          timeout_err_q, timeout_err_d;
   logic          mult_done_prev_q;
   logic          div_done_prev_q;

   logic          can_grant;
   logic          pick1;
   logic          grant0;
   logic          grant1;
   logic          done_rise;
   logic [1:0]    sel_op;
   logic          sel_div;

   // A flush or reset in the same IDLE cycle suppresses any grant.
   assign can_grant = (state_q == S_IDLE) && !bus.flush && !rst;

`ifdef MDU_RR_ARB_EN
   logic rr_ptr_q;

   assign pick1 = bus.req1 & (~bus.req0 | rr_ptr_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
      end else if (grant0) begin
         rr_ptr_q <= 1'b1;
      end else if (grant1) begin
         rr_ptr_q <= 1'b0;
      end
   end
`else
   assign pick1 = bus.req1 & ~bus.req0;
`endif

   assign grant1 = can_grant & pick1;
   assign grant0 = can_grant & bus.req0 & ~pick1;

   assign sel_op  = grant1 ? bus.op1 : bus.op0;
   assign sel_div = grant1 ? bus.is_div1 : bus.is_div0;

   // Only a 0->1 edge of the selected unit's done counts; a level left high is ignored.
   assign done_rise = is_div_q ? (bus.div_done & ~div_done_prev_q)
                               : (bus.mult_done & ~mult_done_prev_q);

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      is_div_d      = is_div_q;
      a_d           = a_q;
      b_d           = b_q;
      kill_d        = kill_q;
      cnt_d         = cnt_q;
      mult_op_d     = 2'b00;
      div_op_d      = 2'b00;
      hilo_we_d     = 1'b0;
      hilo_wdata_d  = hilo_wdata_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         S_IDLE: begin
            if (grant0 || grant1) begin
               op_d     = sel_op;
               is_div_d = sel_div;
               a_d      = grant1 ? bus.a1 : bus.a0;
               b_d      = grant1 ? bus.b1 : bus.b0;
               kill_d   = 1'b0;
               if (sel_div) begin
                  div_op_d = sel_op;
               end else begin
                  mult_op_d = sel_op;
               end
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            kill_d  = kill_q | bus.flush;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            kill_d = kill_q | bus.flush;
            if (done_rise) begin
               hilo_we_d    = ~(kill_q | bus.flush);
               hilo_wdata_d = is_div_q ? bus.div_res : bus.mult_res;
               state_d      = S_COMMIT;
            end else if (cnt_q == CNT_LAST) begin
               timeout_err_d = 1'b1;
               kill_d        = 1'b0;
               state_d       = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            kill_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         op_q             <= 2'b00;
         is_div_q         <= 1'b0;
         a_q              <= '0;
         b_q              <= '0;
         kill_q           <= 1'b0;
         cnt_q            <= '0;
         mult_op_q        <= 2'b00;
         div_op_q         <= 2'b00;
         hilo_we_q        <= 1'b0;
         hilo_wdata_q     <= '0;
         timeout_err_q    <= 1'b0;
         mult_done_prev_q <= 1'b1;
         div_done_prev_q  <= 1'b1;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         is_div_q         <= is_div_d;
         a_q              <= a_d;
         b_q              <= b_d;
         kill_q           <= kill_d;
         cnt_q            <= cnt_d;
         mult_op_q        <= mult_op_d;
         div_op_q         <= div_op_d;
         hilo_we_q        <= hilo_we_d;
         hilo_wdata_q     <= hilo_wdata_d;
         timeout_err_q    <= timeout_err_d;
         mult_done_prev_q <= bus.mult_done;
         div_done_prev_q  <= bus.div_done;
      end
   end

   assign bus.grant0      = grant0;
   assign bus.grant1      = grant1;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.stall0      = (bus.req0 & ~grant0) | (bus.hilo_rd0 & bus.busy);
   assign bus.stall1      = (bus.req1 & ~grant1) | (bus.hilo_rd1 & bus.busy);
   assign bus.mult_op     = mult_op_q;
   assign bus.div_op      = div_op_q;
   assign bus.unit_a      = a_q;
   assign bus.unit_b      = b_q;
   assign bus.hilo_we     = hilo_we_q;
   assign bus.hilo_wdata  = hilo_wdata_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mdu_arbiter.sv
// Scoreboard bench for mdu_arbiter: expected {HI,LO} writes are queued at request time and popped on hilo_we.
module tb_mdu_arbiter;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;

   mdu_arbiter_if bus ();

   mdu_arbiter #(.TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic dv,
                                         input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [31:0] qa;
      logic signed [31:0] qb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      qa = a;
      qb = b;
      if (!dv) begin
         if (op == 2'b10) return sa * sb;
         return {32'd0, a} * {32'd0, b};
      end
      if (op == 2'b10) return {qa % qb, qa / qb};
      return {a % b, a / b};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit p, input logic v, input logic [1:0] op, input logic dv,
                          input logic [31:0] a, input logic [31:0] b);
      if (!p) begin
         bus.req0 = v; bus.op0 = op; bus.is_div0 = dv; bus.a0 = a; bus.b0 = b;
      end else begin
         bus.req1 = v; bus.op1 = op; bus.is_div1 = dv; bus.a1 = a; bus.b1 = b;
      end
   endtask

   task automatic set_done(input logic dv, input logic lvl, input logic [63:0] res);
      bus.mult_done = !dv && lvl;
      bus.div_done  = dv && lvl;
      bus.mult_res  = dv ? ~res : res;
      bus.div_res   = dv ? res : ~res;
   endtask

   task automatic chk_busy();
      check("busy", 64'(bus.busy), 64'(1));
      check("stall0_busy", 64'(bus.stall0), 64'(bus.req0 | bus.hilo_rd0));
      check("stall1_busy", 64'(bus.stall1), 64'(bus.req1 | bus.hilo_rd1));
   endtask

   // Drive a request in an IDLE cycle and expect it to be granted.
   task automatic issue(input bit p, input logic [1:0] op, input logic dv,
                        input logic [31:0] a, input logic [31:0] b, input bit push);
      set_req(p, 1'b1, op, dv, a, b);
      if (push) exp_q.push_back(model(op, dv, a, b));
      @(negedge clk);
      check(p ? "grant1" : "grant0", 64'(p ? bus.grant1 : bus.grant0), 64'(1));
      check(p ? "stall1_grant" : "stall0_grant", 64'(p ? bus.stall1 : bus.stall0), 64'(0));
   endtask

   // From the grant cycle to the following IDLE cycle. mode: 0 plain, 1 flush in WAIT,
   // 2 flush in COMMIT, 3 done level already high before the rise.
   task automatic finish(input bit p, input logic [1:0] op, input logic dv,
                         input logic [31:0] a, input logic [31:0] b, input int dly, input int mode);
      logic [63:0] res;
      res = model(op, dv, a, b);
      cyc();
      if (!p) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      @(negedge clk);
      check("mult_op", 64'(bus.mult_op), 64'(dv ? 2'b00 : op));
      check("div_op", 64'(bus.div_op), 64'(dv ? op : 2'b00));
      check("unit_a", 64'(bus.unit_a), 64'(a));
      check("unit_b", 64'(bus.unit_b), 64'(b));
      chk_busy();
      for (int i = 1; i < dly; i++) begin
         cyc();
         bus.flush = (mode == 1 && i == 1);
         if (mode == 3) set_done(dv, i < dly - 1, res);
         @(negedge clk);
         check("op_pulse_once", 64'({bus.mult_op, bus.div_op}), 64'(0));
         chk_busy();
      end
      cyc();
      bus.flush = 1'b0;
      set_done(dv, 1'b1, res);
      @(negedge clk);
      chk_busy();
      check("hilo_we_at_rise", 64'(bus.hilo_we), 64'(0));
      cyc();
      set_done(dv, 1'b0, res);
      bus.flush = (mode == 2);
      @(negedge clk);
      chk_busy();
      check("hilo_we_commit", 64'(bus.hilo_we), 64'(mode != 1));
      cyc();
      bus.flush = 1'b0;
      @(negedge clk);
      check("busy_end", 64'(bus.busy), 64'(0));
      check("hilo_we_end", 64'(bus.hilo_we), 64'(0));
      if (!bus.req0) check("stall0_end", 64'(bus.stall0), 64'(0));
      if (!bus.req1) check("stall1_end", 64'(bus.stall1), 64'(0));
   endtask

   always @(negedge clk) begin
      if (!rst && bus.hilo_we) begin
         if (exp_q.size() == 0) begin
            check("hilo_unexpected_we", 64'(bus.hilo_we), 64'(0));
         end else begin
            mon_exp = exp_q.pop_front();
            check("hilo_wdata", bus.hilo_wdata, mon_exp);
            $display("hilo write %h", bus.hilo_wdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      bit          first;
      bit          loser;
      logic        dvp[2];
      logic [31:0] ap[2];
      logic [31:0] bp[2];
      checks = 0;
      errors = 0;
      dvp = '{1'b1, 1'b0};
      ap  = '{32'd7, 32'd3};
      bp  = '{32'd2, 32'd4};
      rst = 1'b1;
      bus.flush = 0; bus.hilo_rd0 = 0; bus.hilo_rd1 = 0;
      set_req(0, 0, 2'b00, 0, 0, 0);
      set_req(1, 0, 2'b00, 0, 0, 0);
      set_done(0, 0, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_ops", 64'({bus.mult_op, bus.div_op}), 64'(0));
      check("rst_we", 64'(bus.hilo_we), 64'(0));
      check("rst_wdata", bus.hilo_wdata, 64'(0));
      check("rst_unit_ab", {bus.unit_a, bus.unit_b}, 64'(0));
      check("rst_terr", 64'(bus.timeout_err), 64'(0));
      check("rst_grants", 64'({bus.grant0, bus.grant1, bus.stall0, bus.stall1}), 64'(0));

      // Signed MULT -2 * 3, done rises 5 cycles after the op pulse.
      cyc();
      issue(0, 2'b10, 0, 32'hFFFFFFFE, 32'd3, 1);
      finish(0, 2'b10, 0, 32'hFFFFFFFE, 32'd3, 5, 0);

      // Both pipes request: DIVU 7/2 on pipe 0, MULTU 3*4 on pipe 1.
      first = 1'b0;
`ifdef MDU_RR_ARB_EN
      first = 1'b1;
`endif
      loser = ~first;
      cyc();
      set_req(0, 1, 2'b01, dvp[0], ap[0], bp[0]);
      set_req(1, 1, 2'b01, dvp[1], ap[1], bp[1]);
      exp_q.push_back(model(2'b01, dvp[first], ap[first], bp[first]));
      @(negedge clk);
      check("arb_grant0", 64'(bus.grant0), 64'(!first));
      check("arb_grant1", 64'(bus.grant1), 64'(first));
      check("arb_loser_stall", 64'(loser ? bus.stall1 : bus.stall0), 64'(1));
      finish(first, 2'b01, dvp[first], ap[first], bp[first], 4, 0);
      exp_q.push_back(model(2'b01, dvp[loser], ap[loser], bp[loser]));
      check("arb_second_grant", 64'(loser ? bus.grant1 : bus.grant0), 64'(1));
      finish(loser, 2'b01, dvp[loser], ap[loser], bp[loser], 3, 0);

      // Flush during WAIT of MULT 2x2: runs to done, no write; next request normal.
      cyc();
      issue(0, 2'b10, 0, 32'd2, 32'd2, 0);
      finish(0, 2'b10, 0, 32'd2, 32'd2, 4, 1);
      cyc();
      issue(1, 2'b10, 0, 32'd5, 32'hFFFFFFFD, 1);
      finish(1, 2'b10, 0, 32'd5, 32'hFFFFFFFD, 3, 0);

      // Flush with request in IDLE blocks the grant; flush in COMMIT still writes.
      cyc();
      bus.flush = 1'b1;
      set_req(0, 1, 2'b01, 0, 32'h80000000, 32'd9);
      @(negedge clk);
      check("flush_no_grant", 64'(bus.grant0), 64'(0));
      check("flush_stall0", 64'(bus.stall0), 64'(1));
      cyc();
      bus.flush = 1'b0;
      issue(0, 2'b01, 0, 32'h80000000, 32'd9, 1);
      finish(0, 2'b01, 0, 32'h80000000, 32'd9, 1, 2);

      // HI/LO read on pipe 1 stalls exactly while busy.
      cyc();
      bus.hilo_rd1 = 1'b1;
      issue(0, 2'b10, 1, 32'hFFFFFFF9, 32'd2, 1);
      check("hilo_rd_idle_stall1", 64'(bus.stall1), 64'(0));
      finish(0, 2'b10, 1, 32'hFFFFFFF9, 32'd2, 3, 0);
      cyc();
      bus.hilo_rd1 = 1'b0;

      // Done already high before the op: only a fresh rise commits.
      bus.mult_done = 1'b1;
      cyc();
      issue(0, 2'b10, 0, 32'hFFFFFFFD, 32'd7, 1);
      finish(0, 2'b10, 0, 32'hFFFFFFFD, 32'd7, 4, 3);

      // Done never rises: watchdog fires after 8 WAIT cycles, no write, flag sticks.
      cyc();
      issue(0, 2'b01, 1, 32'd100, 32'd7, 0);
      cyc();
      bus.req0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         @(negedge clk);
         check("wd_busy", 64'(bus.busy), 64'(1));
         check("wd_terr_early", 64'(bus.timeout_err), 64'(0));
      end
      cyc();
      @(negedge clk);
      check("wd_idle", 64'(bus.busy), 64'(0));
      check("wd_terr", 64'(bus.timeout_err), 64'(1));
      check("wd_no_we", 64'(bus.hilo_we), 64'(0));
      cyc();
      issue(1, 2'b01, 0, 32'd11, 32'd13, 1);
      finish(1, 2'b01, 0, 32'd11, 32'd13, 2, 0);
      check("wd_terr_sticky", 64'(bus.timeout_err), 64'(1));

      // Reset in WAIT abandons the op; a later done rise writes nothing.
      cyc();
      issue(0, 2'b10, 0, 32'd6, 32'd7, 0);
      cyc();
      bus.req0 = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("rstw_busy", 64'(bus.busy), 64'(0));
      check("rstw_terr", 64'(bus.timeout_err), 64'(0));
      check("rstw_unit_a", 64'(bus.unit_a), 64'(0));
      check("rstw_wdata", bus.hilo_wdata, 64'(0));
      cyc();
      set_done(0, 1, 64'd42);
      @(negedge clk);
      check("rstw_busy_rise", 64'(bus.busy), 64'(0));
      cyc();
      set_done(0, 0, 64'd42);
      @(negedge clk);
      check("rstw_no_we", 64'(bus.hilo_we), 64'(0));

      cyc();
      check("sb_empty", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
